// File: rtl/issue_stage_if.sv
// IFetch -> issue handshake bundle.
// Master is the fetch unit, slave is issue_stage.
interface issue_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            if_pre_j;

  modport master (
    output if_valid, if_inst, if_pc, if_pre_j,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_inst, if_pc, if_pre_j,
    output if_ready
  );
endinterface

// File: rtl/issue_stage.sv
// RV32I decode-and-issue slot: resolves operands at accept,
// snoops the CDB while held, fires into RS/LSB and ROB.
module issue_stage #(
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  issue_stage_if.slave             fe,
  output logic [4:0]               reg_rs1,
  output logic [4:0]               reg_rs2,
  input  logic                     reg_rs1_rdy,
  input  logic [XLEN-1:0]          reg_rs1_val,
  input  logic [ROB_W-1:0]         reg_rs1_rob,
  input  logic                     reg_rs2_rdy,
  input  logic [XLEN-1:0]          reg_rs2_val,
  input  logic [ROB_W-1:0]         reg_rs2_rob,
  output logic [ROB_W-1:0]         rob_q1_pos,
  output logic [ROB_W-1:0]         rob_q2_pos,
  input  logic                     rob_q1_rdy,
  input  logic [XLEN-1:0]          rob_q1_val,
  input  logic                     rob_q2_rdy,
  input  logic [XLEN-1:0]          rob_q2_val,
  input  logic [ROB_W-1:0]         rob_alloc_pos,
  input  logic                     rob_full,
  input  logic                     rs_full,
  input  logic                     lsb_full,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  output logic                     issue,
  output logic                     rs_en,
  output logic                     lsb_en,
  output logic [ROB_W-1:0]         rob_pos,
  output logic [6:0]               opcode,
  output logic [2:0]               funct3,
  output logic                     funct7,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          imm,
  output logic [XLEN-1:0]          pc,
  output logic                     pre_j,
  output logic                     rs1_rdy,
  output logic [XLEN-1:0]          rs1_val,
  output logic [ROB_W-1:0]         rs1_rob,
  output logic                     rs2_rdy,
  output logic [XLEN-1:0]          rs2_val,
  output logic [ROB_W-1:0]         rs2_rob,
  output logic                     st_ready,
  output logic                     illegal
);

  typedef enum logic {EMPTY, HELD} state_t;

  typedef struct packed {
    logic             rdy;
    logic [XLEN-1:0]  val;
    logic [ROB_W-1:0] rob;
  } opnd_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam opnd_t NO_OPND = '{rdy: 1'b1, val: '0, rob: '0};

  state_t state, state_nxt;

  logic       s_lsb;
  opnd_t      s_op1, s_op2;
  opnd_t      op1, op2, n1, n2;
  logic       fire, accept, tgt_full;
  logic [31:0] inst;

  logic [6:0]  d_op;
  logic [2:0]  d_f3;
  logic        d_f7;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic        d_st, d_ill, d_lsb, use1, use2;
  logic [ROB_W-1:0] tag;

  // Lowest channel wins: scan high to low so low overwrites.
  function automatic opnd_t snoop(opnd_t o);
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && cdb_rob[i*ROB_W +: ROB_W] == o.rob) begin
          r.rdy = 1'b1;
          r.val = cdb_val[i*XLEN +: XLEN];
        end
      end
    end
    return r;
  endfunction

  function automatic opnd_t resolve(
    logic [4:0]       idx,
    logic             rr,
    logic [XLEN-1:0]  rv,
    logic [ROB_W-1:0] rrob,
    logic             qr,
    logic [XLEN-1:0]  qv
  );
    opnd_t r;
    r = '{rdy: 1'b0, val: '0, rob: rrob};
    if (idx == 5'd0)
      r = NO_OPND;
    else if (fire && rd != 5'd0 && rd == idx)
      r = '{rdy: 1'b0, val: '0, rob: rob_pos};
    else if (rr)
      r = '{rdy: 1'b1, val: rv, rob: '0};
    else if (qr)
      r = '{rdy: 1'b1, val: qv, rob: '0};
    else
      r = snoop(r);
    return r;
  endfunction

  assign inst       = fe.if_inst;
  assign reg_rs1    = inst[19:15];
  assign reg_rs2    = inst[24:20];
  assign rob_q1_pos = reg_rs1_rob;
  assign rob_q2_pos = reg_rs2_rob;

  assign tgt_full    = s_lsb ? lsb_full : rs_full;
  assign fire        = state == HELD && !rob_full && !tgt_full
                       && !rollback && rdy;
  assign fe.if_ready = rdy && !rst && !rollback
                       && (state == EMPTY || fire);
  assign accept      = fe.if_valid && fe.if_ready;

  assign issue  = fire;
  assign rs_en  = fire && !s_lsb;
  assign lsb_en = fire && s_lsb;
  assign tag    = fire ? rob_alloc_pos + ROB_W'(1) : rob_alloc_pos;

  always_comb begin
    d_op  = inst[6:0];
    d_f3  = inst[14:12];
    d_f7  = inst[30];
    d_rd  = inst[11:7];
    d_imm = '0;
    d_st  = 1'b0;
    d_ill = 1'b0;
    d_lsb = 1'b0;
    use1  = 1'b1;
    use2  = 1'b1;
    unique case (1'b1)
      d_op == OP_LUI, d_op == OP_AUIPC: begin
        d_imm = {inst[31:12], 12'b0};
        use1  = 1'b0;
        use2  = 1'b0;
      end
      d_op == OP_JAL: begin
        d_imm = {{12{inst[31]}}, inst[19:12], inst[20],
                 inst[30:21], 1'b0};
        use1  = 1'b0;
        use2  = 1'b0;
      end
      d_op == OP_JALR: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        use2  = 1'b0;
      end
      d_op == OP_BR: begin
        d_imm = {{20{inst[31]}}, inst[7], inst[30:25],
                 inst[11:8], 1'b0};
        d_rd  = 5'd0;
      end
      d_op == OP_LD: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        d_lsb = 1'b1;
        use2  = 1'b0;
      end
      d_op == OP_ST: begin
        d_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d_rd  = 5'd0;
        d_st  = 1'b1;
        d_lsb = 1'b1;
      end
      d_op == OP_IMM: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        use2  = 1'b0;
        if (d_f3 != 3'b101) d_f7 = 1'b0;
      end
      d_op == OP_REG: begin
      end
      default: begin
        // Unknown opcodes travel as a nop with no dependencies.
        d_ill = 1'b1;
        d_rd  = 5'd0;
        use1  = 1'b0;
        use2  = 1'b0;
      end
    endcase
  end

  always_comb begin
    op1 = NO_OPND;
    op2 = NO_OPND;
    if (use1)
      op1 = resolve(inst[19:15], reg_rs1_rdy, reg_rs1_val,
                    reg_rs1_rob, rob_q1_rdy, rob_q1_val);
    if (use2)
      op2 = resolve(inst[24:20], reg_rs2_rdy, reg_rs2_val,
                    reg_rs2_rob, rob_q2_rdy, rob_q2_val);
    n1 = s_op1;
    n2 = s_op2;
    if (state == HELD) begin
      n1 = snoop(s_op1);
      n2 = snoop(s_op2);
    end
  end

  assign rs1_rdy = n1.rdy;
  assign rs1_val = n1.val;
  assign rs1_rob = n1.rob;
  assign rs2_rdy = n2.rdy;
  assign rs2_val = n2.val;
  assign rs2_rob = n2.rob;

  always_comb begin
    state_nxt = state;
    if (rollback)
      state_nxt = EMPTY;
    else if (rdy) begin
      if (accept)
        state_nxt = HELD;
      else if (fire)
        state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_lsb    <= 1'b0;
      s_op1    <= NO_OPND;
      s_op2    <= NO_OPND;
      rob_pos  <= '0;
      opcode   <= '0;
      funct3   <= '0;
      funct7   <= 1'b0;
      rd       <= '0;
      imm      <= '0;
      pc       <= '0;
      pre_j    <= 1'b0;
      st_ready <= 1'b0;
      illegal  <= 1'b0;
    end else if (rdy && !rollback) begin
      if (accept) begin
        s_lsb    <= d_lsb;
        s_op1    <= op1;
        s_op2    <= op2;
        rob_pos  <= tag;
        opcode   <= d_op;
        funct3   <= d_f3;
        funct7   <= d_f7;
        rd       <= d_rd;
        imm      <= XLEN'($signed(d_imm));
        pc       <= fe.if_pc;
        pre_j    <= fe.if_pre_j;
        st_ready <= d_st;
        illegal  <= d_ill;
      end else begin
        s_op1 <= n1;
        s_op2 <= n2;
      end
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: decode vector table
// plus hand sequences for stalls, snoop, bypass, flush.
module tb_issue_stage;

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic [4:0]  reg_rs1, reg_rs2;
  logic        reg_rs1_rdy, reg_rs2_rdy;
  logic [31:0] reg_rs1_val, reg_rs2_val;
  logic [3:0]  reg_rs1_rob, reg_rs2_rob;
  logic [3:0]  rob_q1_pos, rob_q2_pos;
  logic        rob_q1_rdy, rob_q2_rdy;
  logic [31:0] rob_q1_val, rob_q2_val;
  logic [3:0]  rob_alloc_pos;
  logic        rob_full, rs_full, lsb_full;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_val;
  logic        issue, rs_en, lsb_en;
  logic [3:0]  rob_pos;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic [4:0]  rd;
  logic [31:0] imm, pc;
  logic        pre_j;
  logic        rs1_rdy, rs2_rdy;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_rob, rs2_rob;
  logic        st_ready, illegal;

  int n_run = 0;
  int n_fail = 0;

  issue_stage_if #(.XLEN(32)) fe ();

  issue_stage #(.ROB_W(4), .NUM_CDB(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fe(fe),
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
    .reg_rs1_rdy(reg_rs1_rdy), .reg_rs1_val(reg_rs1_val),
    .reg_rs1_rob(reg_rs1_rob),
    .reg_rs2_rdy(reg_rs2_rdy), .reg_rs2_val(reg_rs2_val),
    .reg_rs2_rob(reg_rs2_rob),
    .rob_q1_pos(rob_q1_pos), .rob_q2_pos(rob_q2_pos),
    .rob_q1_rdy(rob_q1_rdy), .rob_q1_val(rob_q1_val),
    .rob_q2_rdy(rob_q2_rdy), .rob_q2_val(rob_q2_val),
    .rob_alloc_pos(rob_alloc_pos),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .issue(issue), .rs_en(rs_en), .lsb_en(lsb_en),
    .rob_pos(rob_pos), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .imm(imm), .pc(pc), .pre_j(pre_j),
    .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_rob(rs1_rob),
    .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_rob(rs2_rob),
    .st_ready(st_ready), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  alloc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        st;
    logic        lsb;
    logic [31:0] v1;
    logic [31:0] v2;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fe.if_valid   = 1'b0;
    fe.if_inst    = 32'h0000_0013;
    fe.if_pc      = 32'h0;
    fe.if_pre_j   = 1'b0;
    rdy           = 1'b1;
    rollback      = 1'b0;
    rob_full      = 1'b0;
    rs_full       = 1'b0;
    lsb_full      = 1'b0;
    cdb_valid     = 2'b00;
    cdb_rob       = 8'h00;
    cdb_val       = 64'h0;
    reg_rs1_rdy   = 1'b1;
    reg_rs1_val   = R1;
    reg_rs1_rob   = 4'd0;
    reg_rs2_rdy   = 1'b1;
    reg_rs2_val   = R2;
    reg_rs2_rob   = 4'd0;
    rob_q1_rdy    = 1'b0;
    rob_q1_val    = 32'h0;
    rob_q2_rdy    = 1'b0;
    rob_q2_val    = 32'h0;
    rob_alloc_pos = 4'd0;
  endtask

  task automatic send(input logic [31:0] i, input logic [3:0] a);
    fe.if_valid   = 1'b1;
    fe.if_inst    = i;
    rob_alloc_pos = a;
  endtask

  initial begin
    vt[0] = '{32'h0050_0093, 4'd3, 7'h13, 3'd0, 1'b0, 5'd1,
              32'h0000_0005, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[1] = '{32'h0020_A423, 4'd4, 7'h23, 3'd2, 1'b0, 5'd0,
              32'h0000_0008, 1'b1, 1'b1, R1, R2};
    vt[2] = '{32'hFE00_0EE3, 4'd5, 7'h63, 3'd0, 1'b1, 5'd0,
              32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[3] = '{32'h4020_81B3, 4'd6, 7'h33, 3'd0, 1'b1, 5'd3,
              32'h0, 1'b0, 1'b0, R1, R2};
    vt[4] = '{32'h1234_52B7, 4'd7, 7'h37, 3'd5, 1'b0, 5'd5,
              32'h1234_5000, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[5] = '{32'h4030_D213, 4'd8, 7'h13, 3'd5, 1'b1, 5'd4,
              32'h0000_0403, 1'b0, 1'b0, R1, 32'h0};
    vt[6] = '{32'h0080_00EF, 4'd9, 7'h6F, 3'd0, 1'b0, 5'd1,
              32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[7] = '{32'hFFF1_2303, 4'd10, 7'h03, 3'd2, 1'b1, 5'd6,
              32'hFFFF_FFFF, 1'b0, 1'b1, R1, 32'h0};
    vt[8] = '{32'hFFFF_F397, 4'd11, 7'h17, 3'd7, 1'b1, 5'd7,
              32'hFFFF_F000, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[9] = '{32'hFFF0_F293, 4'd12, 7'h13, 3'd7, 1'b0, 5'd5,
              32'hFFFF_FFFF, 1'b0, 1'b0, R1, 32'h0};

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_ifready", 32'(fe.if_ready), 32'd0);
    chk("rst_robpos", 32'(rob_pos), 32'd0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_rs1_rdy", 32'(rs1_rdy), 32'd1);
    chk("rst_rs2_rdy", 32'(rs2_rdy), 32'd1);
    chk("rst_rd", 32'(rd), 32'd0);
    rst = 1'b0;
    #1;
    chk("ifready_after_rst", 32'(fe.if_ready), 32'd1);

    // Decode table: accept, then check the issuing slot.
    for (int i = 0; i < 10; i++) begin
      send(vt[i].inst, vt[i].alloc);
      fe.if_pc    = 32'h1000 + 32'(i * 4);
      fe.if_pre_j = i[0];
      #1;
      chk("v_ifready", 32'(fe.if_ready), 32'd1);
      tick();
      idle();
      #1;
      chk("v_issue", 32'(issue), 32'd1);
      chk("v_rs_en", 32'(rs_en), 32'(!vt[i].lsb));
      chk("v_lsb_en", 32'(lsb_en), 32'(vt[i].lsb));
      chk("v_robpos", 32'(rob_pos), 32'(vt[i].alloc));
      chk("v_opcode", 32'(opcode), 32'(vt[i].op));
      chk("v_funct3", 32'(funct3), 32'(vt[i].f3));
      chk("v_funct7", 32'(funct7), 32'(vt[i].f7));
      chk("v_rd", 32'(rd), 32'(vt[i].rd));
      chk("v_imm", imm, vt[i].imm);
      chk("v_st", 32'(st_ready), 32'(vt[i].st));
      chk("v_pc", pc, 32'h1000 + 32'(i * 4));
      chk("v_prej", 32'(pre_j), 32'(i[0]));
      chk("v_rs1_rdy", 32'(rs1_rdy), 32'd1);
      chk("v_rs1_val", rs1_val, vt[i].v1);
      chk("v_rs2_rdy", 32'(rs2_rdy), 32'd1);
      chk("v_rs2_val", rs2_val, vt[i].v2);
      chk("v_illegal", 32'(illegal), 32'd0);
      tick();
      chk("v_drained", 32'(issue), 32'd0);
    end

    // Store stalled by a full LSB for three cycles.
    send(32'h0020_A423, 4'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      send(32'h0050_0093, 4'd2);
      lsb_full = 1'b1;
      #1;
      chk("sw_stall_ifready", 32'(fe.if_ready), 32'd0);
      chk("sw_stall_issue", 32'(issue), 32'd0);
      tick();
    end
    idle();
    #1;
    chk("sw_lsb_en", 32'(lsb_en), 32'd1);
    chk("sw_imm", imm, 32'd8);
    chk("sw_rd", 32'(rd), 32'd0);
    chk("sw_st", 32'(st_ready), 32'd1);
    chk("sw_robpos", 32'(rob_pos), 32'd1);
    tick();

    // Held ADD with rs1 pending on tag 5, woken by CDB channel 1.
    send(32'h0020_81B3, 4'd2);
    reg_rs1_rdy = 1'b0;
    reg_rs1_rob = 4'd5;
    rob_full = 1'b1;
    tick();
    idle();
    rob_full = 1'b1;
    #1;
    chk("snp_pending_rdy", 32'(rs1_rdy), 32'd0);
    chk("snp_pending_rob", 32'(rs1_rob), 32'd5);
    chk("snp_hold_issue", 32'(issue), 32'd0);
    cdb_valid = 2'b10;
    cdb_rob   = {4'd5, 4'd9};
    cdb_val   = {32'h0000_1234, 32'hDEAD_BEEF};
    tick();
    cdb_valid = 2'b00;
    #1;
    chk("snp_rs1_rdy", 32'(rs1_rdy), 32'd1);
    chk("snp_rs1_val", rs1_val, 32'h0000_1234);
    chk("snp_rs2_val", rs2_val, R2);
    chk("snp_still_held", 32'(issue), 32'd0);
    rob_full = 1'b0;
    #1;
    chk("snp_fire", 32'(issue), 32'd1);
    tick();

    // Both operands pending; two channels match in the fire cycle.
    send(32'h0020_81B3, 4'd3);
    reg_rs1_rdy = 1'b0;
    reg_rs1_rob = 4'd5;
    reg_rs2_rdy = 1'b0;
    reg_rs2_rob = 4'd6;
    rob_full = 1'b1;
    tick();
    idle();
    cdb_valid = 2'b11;
    cdb_rob   = {4'd6, 4'd6};
    cdb_val   = {32'h0000_BBBB, 32'h0000_AAAA};
    #1;
    chk("fire_snp_issue", 32'(issue), 32'd1);
    chk("fire_snp_rs2_rdy", 32'(rs2_rdy), 32'd1);
    chk("fire_snp_rs2_val", rs2_val, 32'h0000_AAAA);
    chk("fire_snp_rs1_rdy", 32'(rs1_rdy), 32'd0);
    chk("fire_snp_rs1_rob", 32'(rs1_rob), 32'd5);
    tick();
    idle();

    // Back-to-back dependent ADDIs: same-cycle bypass of rd.
    send(32'h0010_0093, 4'd6);
    tick();
    send(32'h0010_8113, 4'd6);
    #1;
    chk("b2b_first_issue", 32'(issue), 32'd1);
    chk("b2b_first_pos", 32'(rob_pos), 32'd6);
    chk("b2b_ifready", 32'(fe.if_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("b2b_issue", 32'(issue), 32'd1);
    chk("b2b_pos", 32'(rob_pos), 32'd7);
    chk("b2b_rs1_rdy", 32'(rs1_rdy), 32'd0);
    chk("b2b_rs1_rob", 32'(rs1_rob), 32'd6);
    chk("b2b_rd", 32'(rd), 32'd2);
    tick();

    // Rollback flushes a held slot and blocks a new accept.
    send(32'h0050_0093, 4'd2);
    rob_full = 1'b1;
    tick();
    send(32'h0010_0093, 4'd3);
    rollback = 1'b1;
    rob_full = 1'b0;
    #1;
    chk("rb_ifready", 32'(fe.if_ready), 32'd0);
    chk("rb_issue", 32'(issue), 32'd0);
    tick();
    idle();
    #1;
    chk("rb_after_issue", 32'(issue), 32'd0);
    chk("rb_after_ifready", 32'(fe.if_ready), 32'd1);
    tick();
    chk("rb_after2_issue", 32'(issue), 32'd0);

    // Tag wrap: fire+accept with alloc 15 gives the BEQ tag 0.
    send(32'h0050_0093, 4'd15);
    tick();
    send(32'hFE00_0EE3, 4'd15);
    #1;
    chk("wrap_first_pos", 32'(rob_pos), 32'd15);
    chk("wrap_first_issue", 32'(issue), 32'd1);
    tick();
    idle();
    #1;
    chk("wrap_pos", 32'(rob_pos), 32'd0);
    chk("wrap_imm", imm, 32'hFFFF_FFFC);
    chk("wrap_rd", 32'(rd), 32'd0);
    chk("wrap_rs_en", 32'(rs_en), 32'd1);
    tick();

    // Global enable low freezes the held slot.
    send(32'h0050_0093, 4'd2);
    tick();
    idle();
    rdy = 1'b0;
    #1;
    chk("rdy0_issue", 32'(issue), 32'd0);
    chk("rdy0_ifready", 32'(fe.if_ready), 32'd0);
    tick();
    tick();
    rdy = 1'b1;
    #1;
    chk("rdy1_issue", 32'(issue), 32'd1);
    chk("rdy1_pos", 32'(rob_pos), 32'd2);
    tick();

    // Unknown opcode is held and goes to RS.
    send(32'h0000_007F, 4'd4);
    tick();
    idle();
    #1;
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_rs_en", 32'(rs_en), 32'd1);
    chk("ill_lsb_en", 32'(lsb_en), 32'd0);
    tick();

    // Reset while holding drops the slot.
    send(32'h0050_0093, 4'd9);
    rob_full = 1'b1;
    tick();
    idle();
    rob_full = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rob_full = 1'b0;
    #1;
    chk("mid_rst_issue", 32'(issue), 32'd0);
    chk("mid_rst_pos", 32'(rob_pos), 32'd0);
    chk("mid_rst_imm", imm, 32'h0);
    chk("mid_rst_rs1_rdy", 32'(rs1_rdy), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Registered decode-and-issue stage between IFetch and the RS/LSB/ROB back end.
- Decodes RV32I and resolves operands through RegFile, ROB lookup and CDB snooping.
- Holds one decoded instruction in a slot until its target queue and the ROB can take it.
- Keeps snooping all CDB channels while the instruction is held.

Parameters:
ROB_W, 4, ROB tag width (ROB depth 2^ROB_W)
NUM_CDB, 2, number of CDB broadcast channels snooped
XLEN, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
rollback  in  1  mispredict flush
if_valid  in  1  IFetch instruction valid
if_ready  out  1  stage accepts instruction this cycle
if_inst  in  32  instruction word
if_pc  in  XLEN  instruction PC
if_pre_j  in  1  predicted taken
reg_rs1/reg_rs2  out  5 each  RegFile read indices, wired from if_inst[19:15] and if_inst[24:20]
reg_rsN_rdy/_val/_rob  in  1/XLEN/ROB_W  RegFile result per source N
rob_qN_pos  out  ROB_W  ROB lookup tag = reg_rsN_rob
rob_qN_rdy/_val  in  1/XLEN  ROB entry completed and its value
rob_alloc_pos  in  ROB_W  tag the next ROB allocation receives
rob_full, rs_full, lsb_full  in  1 each  no free entry
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_rob  in  NUM_CDB*ROB_W  broadcast tags, channel i at bits [i*ROB_W +: ROB_W]
cdb_val  in  NUM_CDB*XLEN  broadcast values
issue  out  1  slot fires this cycle (to ROB)
rs_en, lsb_en  out  1 each  fire to RS / to LSB
rob_pos  out  ROB_W  slot tag
opcode  out  7  slot field
funct3  out  3  slot field
funct7  out  1  slot field
rd  out  5  slot field; 0 for S/B
imm  out  XLEN  slot field
pc  out  XLEN  slot field
pre_j  out  1  slot field
rs1_rdy/rs1_val/rs1_rob  out  1/XLEN/ROB_W  slot operand 1
rs2_rdy/rs2_val/rs2_rob  out  1/XLEN/ROB_W  slot operand 2
st_ready  out  1  store: ROB may mark entry ready at issue
illegal  out  1  unknown opcode held

Behaviour:
- Slot states EMPTY/HELD. Reset: EMPTY; every output 0 except rs1_rdy and rs2_rdy, which reset to 1.
- tgt = LSB for opcodes L/S, RS for every other legal opcode.
- fire = HELD && !rob_full && !(tgt full) && !rollback && rdy. Combinational from slot registers and full flags.
- issue = fire. rs_en = fire && tgt==RS. lsb_en = fire && tgt==LSB.
- if_ready = rdy && !rst && !rollback && (EMPTY || fire).
- Accept (if_valid && if_ready): slot loads next edge. State HELD. One-cycle decode-to-issue latency minimum.
- Accept with no fire: state goes EMPTY -> HELD.
- Fire with no accept: state goes HELD -> EMPTY.
- Fire and accept together: state stays HELD with the new contents.
- Tag at accept: rob_alloc_pos if EMPTY; rob_alloc_pos+1 mod 2^ROB_W if the slot fires the same cycle.
- Operand resolve at accept, priority order:
  - index 0 -> rdy=1, val=0.
  - same-cycle bypass: slot fires, slot rd!=0, slot rd==index -> rdy=0, rob=slot rob_pos.
  - reg_rdy -> RegFile value.
  - rob_q_rdy -> ROB value.
  - CDB match on any channel -> that channel's value.
  - otherwise rdy=0, rob=reg_rob.
- Unused operand forced rdy=1, val=0, rob=0: rs2 for L/I-type/JALR; both for LUI/AUIPC/JAL.
- imm formats:
  - I-type and L: sign-extended inst[31:20].
  - S: sign-extended {inst[31:25], inst[11:7]}.
  - B: {sign, inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {sign, inst[19:12], inst[20], inst[30:21], 0}.
- rd forced 0 for S/B. st_ready=1 for S only.
- funct7 = inst[30], except I-type funct3!=101 -> 0.
- HELD snoop: each cycle, any operand with rdy=0 whose rob matches a valid CDB channel sets rdy=1 and takes that value.
- Multiple CDB matches: lowest channel index wins. A match in the fire cycle still updates the operands presented downstream (bypassed onto the outputs).
- illegal unknown opcode: held, fires to RS only. RS and ROB treat it as a nop.
- rollback: slot -> EMPTY next edge, no fire, no accept, regardless of if_valid. Takes priority over rdy.
- rdy=0: no state change, issue/rs_en/lsb_en forced 0.
- rst mid-hold: slot dropped, outputs return to reset values.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), rob_alloc_pos=3, fulls 0 -> issue pulses next cycle: rs_en=1, rob_pos=3, imm=5, rs1_rdy=1, rs1_val=0, rs2_rdy=1.
- SW x2,8(x1) with lsb_full=1 for 3 cycles -> if_ready=0, issue=0 for 3 cycles. lsb_en=1 in the 4th cycle with imm=8, rd=0, st_ready=1.
- Held ADD x3,x1,x2 where rs1 is pending on tag 5 -> cdb_valid=2'b10, cdb_rob[1]=5, cdb_val=0x1234 -> next cycle rs1_rdy=1, rs1_val=0x1234.
- Back-to-back ADDI x1,x0,1 then ADDI x2,x1,1, rob_alloc_pos=6 -> second instruction gets rob_pos=7, rs1_rdy=0, rs1_rob=6.
- Instruction held, rollback=1 with if_valid=1 -> slot empties, no issue that cycle or the next, if_ready=0 during rollback.
- BEQ with imm=-4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0, rs_en=1. rob_alloc_pos=15 with fire+accept -> next tag wraps to 0.
